// File: rtl/jt51_pkg.sv
// Shared JT51 constants: slot geometry, operator group encoding, channel config payload.
package jt51_pkg;

  localparam int unsigned SLOTS       = 32;
  localparam int unsigned CHANNELS    = 8;
  localparam int unsigned SAMPLE_SLOT = 16;
  localparam int unsigned SLOT_W      = 5;
  localparam int unsigned CH_W        = 3;
  localparam int unsigned CON_W       = 3;
  localparam int unsigned RL_W        = 2;
  localparam int unsigned CFG_W       = CON_W + RL_W;

  typedef enum logic [1:0] {
    GRP_M1 = 2'd0,
    GRP_M2 = 2'd1,
    GRP_C1 = 2'd2,
    GRP_C2 = 2'd3
  } grp_e;

  typedef struct packed {
    logic [CON_W-1:0] con;
    logic [RL_W-1:0]  rl;
  } ch_cfg_t;

  function automatic grp_e slot_grp(input logic [SLOT_W-1:0] slot);
    return grp_e'(slot[4:3]);
  endfunction

endpackage

// File: rtl/jt51_acc_seq_snap.sv
// Per-channel {con,rl} snapshot: written during M1, read by channel for the other groups.
module jt51_acc_seq_snap
  import jt51_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [CH_W-1:0]  waddr_i,
  input  logic [CFG_W-1:0] wdata_i,
  input  logic [CH_W-1:0]  raddr_i,
  output logic [CFG_W-1:0] rdata_o
);

  logic [CFG_W-1:0] tbl_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) tbl_q[i] <= '0;
    end else if (we_i) begin
      tbl_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/jt51_acc_seq.sv
// Accumulator slot sequencer: group strobes, channel config alignment, sample handshake.
// Optional per-sample config lock via JT51_ACC_SEQ_LOCK_EN.
module jt51_acc_seq
  import jt51_pkg::*;
#(
  parameter int unsigned ACC_DLY = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  output logic [4:0] issue_slot,
  output logic [2:0] ch_sel,
  input  logic [2:0] ch_con,
  input  logic [1:0] ch_rl,
  output logic       m1_enters,
  output logic       m2_enters,
  output logic       c1_enters,
  output logic       c2_enters,
  output logic       op31_acc,
  output logic [2:0] con_I,
  output logic [1:0] rl_I,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overrun
);

  localparam logic [SLOT_W-1:0] ACC_RST = SLOT_W'((SLOTS - (ACC_DLY % SLOTS)) % SLOTS);

  logic [SLOT_W-1:0] issue_q, issue_d;
  logic [SLOT_W-1:0] acc_q, acc_d, acc_nx;
  ch_cfg_t           cfg_q, cfg_d, cfg_live, cfg_nx;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              sample_evt;

  assign acc_nx   = acc_q + SLOT_W'(1);
  assign cfg_live = '{con: ch_con, rl: ch_rl};

  // Strobes decode from the acc_slot register only
  always_comb begin
    m1_enters = (slot_grp(acc_q) == GRP_M1);
    m2_enters = (slot_grp(acc_q) == GRP_M2);
    c1_enters = (slot_grp(acc_q) == GRP_C1);
    c2_enters = (slot_grp(acc_q) == GRP_C2);
    op31_acc  = (acc_q == SLOT_W'(SLOTS - 1));
    ch_sel    = acc_nx[CH_W-1:0];
  end

`ifdef JT51_ACC_SEQ_LOCK_EN
  logic             snap_we;
  logic [CFG_W-1:0] snap_rdata;

  assign snap_we = cen & (slot_grp(acc_nx) == GRP_M1);

  jt51_acc_seq_snap u_snap (
    .clk     (clk),
    .rst     (rst),
    .we_i    (snap_we),
    .waddr_i (ch_sel),
    .wdata_i (cfg_live),
    .raddr_i (ch_sel),
    .rdata_o (snap_rdata)
  );

  assign cfg_nx = snap_we ? cfg_live : ch_cfg_t'(snap_rdata);
`else
  assign cfg_nx = cfg_live;
`endif

  assign sample_evt = cen & (acc_nx == SLOT_W'(SAMPLE_SLOT));

  always_comb begin
    issue_d = issue_q;
    acc_d   = acc_q;
    cfg_d   = cfg_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (cen) begin
      issue_d = issue_q + SLOT_W'(1);
      acc_d   = acc_nx;
      cfg_d   = cfg_nx;
    end
    // A coincident accept keeps valid high without flagging overrun
    if (sample_evt) begin
      valid_d = 1'b1;
      if (valid_q && !sample_ready) ovr_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= '0;
      acc_q   <= ACC_RST;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      issue_q <= issue_d;
      acc_q   <= acc_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign issue_slot   = issue_q;
  assign con_I        = cfg_q.con;
  assign rl_I         = cfg_q.rl;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_jt51_acc_seq.sv
// Self-checking bench for jt51_acc_seq: slot-level model plus directed literal checks.
module tb_jt51_acc_seq;
  import jt51_pkg::*;

  localparam int unsigned ACC_DLY = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       sample_ready = 1'b0;
  logic [4:0] issue_slot;
  logic [2:0] ch_sel;
  logic [2:0] ch_con;
  logic [1:0] ch_rl;
  logic       m1_enters, m2_enters, c1_enters, c2_enters, op31_acc;
  logic [2:0] con_I;
  logic [1:0] rl_I;
  logic       sample_valid, overrun;

  logic [2:0] reg_con [8];
  logic [1:0] reg_rl  [8];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  jt51_acc_seq #(.ACC_DLY(ACC_DLY)) dut (
    .clk          (clk),
    .rst          (rst),
    .cen          (cen),
    .issue_slot   (issue_slot),
    .ch_sel       (ch_sel),
    .ch_con       (ch_con),
    .ch_rl        (ch_rl),
    .m1_enters    (m1_enters),
    .m2_enters    (m2_enters),
    .c1_enters    (c1_enters),
    .c2_enters    (c2_enters),
    .op31_acc     (op31_acc),
    .con_I        (con_I),
    .rl_I         (rl_I),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  // Register file: combinational lookup by channel address
  assign ch_con = reg_con[ch_sel];
  assign ch_rl  = reg_rl[ch_sel];

  // Model state: slot count since reset, aligned channel config, handshake flags
  logic [4:0] m_issue;
  logic [2:0] m_con;
  logic [1:0] m_rl;
  logic       m_valid, m_ovr;
  logic [4:0] m_snap [8];

  function automatic logic [4:0] acc_of(input logic [4:0] issue);
    return 5'((int'(issue) + 32 - int'(ACC_DLY)) % 32);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_issue <= '0;
      m_con   <= '0;
      m_rl    <= '0;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
      for (int i = 0; i < 8; i++) m_snap[i] <= '0;
    end else begin
      if (cen) begin
        m_issue <= m_issue + 5'd1;
`ifdef JT51_ACC_SEQ_LOCK_EN
        if (acc_of(m_issue + 5'd1) < 5'd8) begin
          m_con <= reg_con[acc_of(m_issue + 5'd1) % 8];
          m_rl  <= reg_rl[acc_of(m_issue + 5'd1) % 8];
          m_snap[acc_of(m_issue + 5'd1) % 8] <= {reg_con[acc_of(m_issue + 5'd1) % 8],
                                                 reg_rl[acc_of(m_issue + 5'd1) % 8]};
        end else begin
          m_con <= m_snap[acc_of(m_issue + 5'd1) % 8][4:2];
          m_rl  <= m_snap[acc_of(m_issue + 5'd1) % 8][1:0];
        end
`else
        m_con <= reg_con[acc_of(m_issue + 5'd1) % 8];
        m_rl  <= reg_rl[acc_of(m_issue + 5'd1) % 8];
`endif
      end
      if (cen && acc_of(m_issue + 5'd1) == 5'(SAMPLE_SLOT)) begin
        m_valid <= 1'b1;
        if (m_valid && !sample_ready) m_ovr <= 1'b1;
      end else if (m_valid && sample_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [4:0] a;
    a = acc_of(m_issue);
    chk("issue_slot", int'(issue_slot), int'(m_issue));
    chk("group_strobes", int'({c2_enters, c1_enters, m2_enters, m1_enters}),
        1 << int'(a / 8));
    chk("op31_acc", int'(op31_acc), int'(a == 5'd31));
    chk("ch_sel", int'(ch_sel), (int'(a) + 1) % 8);
    chk("con_I", int'(con_I), int'(m_con));
    chk("rl_I", int'(rl_I), int'(m_rl));
    chk("sample_valid", int'(sample_valid), int'(m_valid));
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  // Inputs change on the falling edge; outputs compared there against the model
  task automatic tick(input logic c, input logic r);
    cen = c;
    sample_ready = r;
    @(posedge clk);
    @(negedge clk);
    if (chk_en) check_model();
  endtask

  task automatic run_to_acc(input logic [4:0] target, input logic r);
    int n;
    n = 0;
    tick(1'b1, r);
    while (acc_of(m_issue) != target && n < 100) begin
      tick(1'b1, r);
      n++;
    end
    chk("acc_reach_bound", int'(acc_of(m_issue)), int'(target));
  endtask

  int op31_cnt, valid_cnt, n;

  initial begin
    for (int i = 0; i < 8; i++) begin
      reg_con[i] = 3'(i);
      reg_rl[i]  = 2'(i);
    end
    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk_en = 1'b1;
    check_model();
    rst = 1'b0;

    // Reset state: acc_slot = 19 -> C1 group, next channel 4
    chk("rst_issue", int'(issue_slot), 0);
    chk("rst_c1", int'(c1_enters), 1);
    chk("rst_m1", int'(m1_enters), 0);
    chk("rst_op31", int'(op31_acc), 0);
    chk("rst_ch_sel", int'(ch_sel), 4);
    chk("rst_con", int'(con_I), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_ovr", int'(overrun), 0);

    // Ready tied high: one valid clk per sample, op31 once per 32 cens
    op31_cnt = 0;
    valid_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, 1'b1);
      if (i == 0) begin
        chk("first_con", int'(con_I), 4);
        chk("first_rl", int'(rl_I), 0);
        chk("first_c1", int'(c1_enters), 1);
      end
      if (op31_acc) op31_cnt++;
      if (sample_valid) valid_cnt++;
    end
    chk("op31_count", op31_cnt, 2);
    chk("valid_count", valid_cnt, 2);
    chk("ovr_ready1", int'(overrun), 0);

    // Gated cen: state holds on idle clocks
    for (int i = 0; i < 20; i++) tick(1'(i % 2 == 0), 1'b1);

    // Ready low for 70 cens: second event raises overrun
    for (int i = 0; i < 70; i++) tick(1'b1, 1'b0);
    chk("stall_valid", int'(sample_valid), 1);
    chk("stall_ovr", int'(overrun), 1);
    tick(1'b0, 1'b1);
    chk("accept_valid", int'(sample_valid), 0);
    chk("accept_ovr", int'(overrun), 1);

    // Channel 3 config change in the middle of a sample
    reg_con[3] = 3'd5;
    run_to_acc(5'd3, 1'b0);
    chk("ch3_m1_con", int'(con_I), 5);
    run_to_acc(5'd12, 1'b0);
    reg_con[3] = 3'd2;
    run_to_acc(5'd19, 1'b0);
`ifdef JT51_ACC_SEQ_LOCK_EN
    chk("lock_c1_con", int'(con_I), 5);
`else
    chk("live_c1_con", int'(con_I), 2);
`endif
    run_to_acc(5'd27, 1'b0);
`ifdef JT51_ACC_SEQ_LOCK_EN
    chk("lock_c2_con", int'(con_I), 5);
`else
    chk("live_c2_con", int'(con_I), 2);
`endif
    run_to_acc(5'd3, 1'b0);
    chk("next_m1_con", int'(con_I), 2);

    // Mid-cycle reset with a pending sample
    n = 0;
    tick(1'b1, 1'b0);
    while (!(acc_of(m_issue) == 5'd25 && m_valid) && n < 100) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("pre_rst_valid", int'(sample_valid), 1);
    chk("pre_rst_acc25", int'(acc_of(m_issue)), 25);
    rst = 1'b1;
    tick(1'b1, 1'b0);
    rst = 1'b0;
    chk("mid_rst_issue", int'(issue_slot), 0);
    chk("mid_rst_c1", int'(c1_enters), 1);
    chk("mid_rst_ch_sel", int'(ch_sel), 4);
    chk("mid_rst_valid", int'(sample_valid), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'(i % 3 == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
